// File: rtl/fifo_uart_pkg.sv
// Shared types and line levels for the FIFO-draining UART transmitter.
// Optional parity build: FIFO_UART_TX_PARITY_EN (see fifo_uart_tx).
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/fifo_uart_baud_gen.sv
// Bit-period counter: counts while en, wraps at CLKS_PER_BIT-1 and flags that
// cycle with bit_tick. clr has priority and restarts the bit period.
module fifo_uart_baud_gen #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the FIFO and sends them as start/data(LSB first)/stop frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a non-empty FIFO
// REQ    | fifo_read high, retried while the FIFO write strobe blocks it
// LOAD   | capture fifo_data_out, clear counters
// START  | start bit
// DATA   | WIDTH data bits, LSB first
// PARITY | even parity of the captured word (parity build only)
// STOP   | stop bit, frame_done on its last cycle
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_empty,
  input  logic             fifo_write,
  output logic             fifo_read,
  output logic             tx,
  output logic             tx_busy,
  output logic             frame_done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        state, state_nx;
  logic [WIDTH-1:0] shift, shift_nx;
  logic [BW-1:0]    bit_cnt, bit_cnt_nx;
  logic             tx_nx;
  logic             bit_tick;
  logic             baud_en;

`ifdef FIFO_UART_TX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit <= 1'b0;
    end else if (state == LOAD) begin
      par_bit <= ^fifo_data_out;
    end
  end
`endif

  assign baud_en = (state == START) || (state == DATA) ||
                   (state == PARITY) || (state == STOP);

  fifo_uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == LOAD),
    .en      (baud_en),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_nx   = state;
    shift_nx   = shift;
    bit_cnt_nx = bit_cnt;
    case (state)
      IDLE:  if (!fifo_empty) state_nx = REQ;
      // The FIFO drops a read that coincides with a write, so only then is it taken.
      REQ:   if (!fifo_empty && !fifo_write) state_nx = LOAD;
      LOAD: begin
        shift_nx   = fifo_data_out;
        bit_cnt_nx = '0;
        state_nx   = START;
      end
      START: if (bit_tick) state_nx = DATA;
      DATA: begin
        if (bit_tick) begin
          shift_nx = shift >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nx = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_nx   = PARITY;
`else
            state_nx   = STOP;
`endif
          end else begin
            bit_cnt_nx = bit_cnt + BW'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (bit_tick) state_nx = STOP;
`endif
      STOP:  if (bit_tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // tx is registered from the next state so the line level lines up with the state.
    tx_nx = IDLE_LEVEL;
    case (state_nx)
      START:  tx_nx = START_LEVEL;
      DATA:   tx_nx = shift_nx[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_nx = par_bit;
`endif
      STOP:   tx_nx = STOP_LEVEL;
      default: tx_nx = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= IDLE_LEVEL;
    end else begin
      state   <= state_nx;
      shift   <= shift_nx;
      bit_cnt <= bit_cnt_nx;
      tx      <= tx_nx;
    end
  end

  assign fifo_read  = (state == REQ);
  assign tx_busy    = (state != IDLE);
  assign frame_done = (state == STOP) && bit_tick;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the team's 16-bit FIFO. Pops one word at a time and transmits it on a single-wire asynchronous serial line.
- Frame format: start bit 0, WIDTH data bits LSB first, optional parity bit, stop bit 1.
- Handles the FIFO's write-over-read priority by snooping the FIFO write strobe.
- Sits between the FIFO read port and the board-level TX pin.

Parameters:
- WIDTH, 16, data word width; must equal the FIFO WIDTH.
- CLKS_PER_BIT, 8, clk cycles per serial bit; legal range 2..65535.

Ports:
- clk  input  1  system clock, all state changes on posedge
- rst  input  1  asynchronous, active-low reset
- fifo_data_out  input  WIDTH  FIFO read data; valid the cycle after an accepted read
- fifo_empty  input  1  FIFO empty flag
- fifo_write  input  1  snoop of the FIFO write strobe; when high, the FIFO ignores a read in that cycle
- fifo_read  output  1  read request to the FIFO
- tx  output  1  serial line, idle high
- tx_busy  output  1  high from REQ through STOP
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (asynchronous, rst=0): state IDLE, tx=1, fifo_read=0, tx_busy=0, frame_done=0, all counters 0, shift register 0. Reset mid-frame returns tx to 1 immediately; the in-flight word is lost and is not re-read.
- fifo_read = (state==REQ), decoded from the state register only. tx is registered. tx_busy = (state!=IDLE).
- IDLE: tx=1. If fifo_empty==0, go to REQ on the next edge.
- REQ: fifo_read=1.
  - Read is accepted iff fifo_empty==0 and fifo_write==0 in the same cycle; then go to LOAD.
  - Otherwise stay in REQ and retry every cycle.
- LOAD (1 cycle): capture fifo_data_out into the shift register, clear the bit-period counter and bit counter, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shift[0]; shift right after each CLKS_PER_BIT cycles. After WIDTH bits go to PARITY (if enabled) or STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 in the final cycle.
  - Go to IDLE. If the FIFO is non-empty, REQ follows one cycle later.
- Latency: first tx falling edge occurs 3 clk cycles after fifo_empty falls (IDLE→REQ→LOAD→START), absent a write collision.
- Frame length: (WIDTH+2)*CLKS_PER_BIT cycles (+CLKS_PER_BIT with parity).
- Back-to-back words: 3 idle-high cycles (IDLE, REQ, LOAD) separate consecutive frames.
- Bit-period counter width is $clog2(CLKS_PER_BIT). Bit counter width is $clog2(WIDTH+1). Counters wrap to 0 at terminal count, never free-run.
- fifo_empty is ignored outside IDLE/REQ. The block never issues more than one accepted read per frame.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: state PARITY is inserted between DATA and STOP. tx = XOR of the captured word (even parity) for CLKS_PER_BIT cycles.
- Undefined: no PARITY state, and DATA goes directly to STOP.

Decomposition:
- Package fifo_uart_pkg:
  - tx_state_t enum: IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
  - Constants: IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- Sub-module fifo_uart_baud_gen: bit-period counter with sync clear input and a one-cycle bit_tick output at count CLKS_PER_BIT-1.

Test Plan:
1. WIDTH=16, CLKS_PER_BIT=4, push 16'hA5C3 into the empty FIFO -> fifo_read high exactly 1 cycle; tx = 0, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1, each held 4 cycles; frame_done pulses once at cycle 72 after LOAD.
2. Push 16'h0001, 16'hFFFF, 16'h8000 back-to-back -> three frames in FIFO order, 3 idle-high cycles between frames, exactly 3 accepted reads, fifo_empty=1 after the third LOAD.
3. Hold fifo_write=1 for 3 cycles while in REQ (FIFO non-empty) -> fifo_read stays high for 4 cycles; LOAD follows the first cycle with fifo_write=0; the transmitted word equals the oldest FIFO entry.
4. Deassert rst during DATA bit 5 of 16'h1234 -> tx=1, tx_busy=0, fifo_read=0 immediately. After release with the FIFO empty, tx stays 1 and there are no reads.
5. FIFO_UART_TX_PARITY_EN defined, word 16'h0007 -> parity bit 1 after bit 15; frame length 19*CLKS_PER_BIT. Word 16'h0003 -> parity bit 0.
6. FIFO empty for 1000 cycles after reset -> tx=1, fifo_read=0, tx_busy=0, frame_done=0 throughout.
